// File: rtl/pad_in_filter_if.sv
// Bundle of the per-pad conditioning signals between the pad ring side and the
// filter. The filter itself uses the slave modport.
interface pad_in_filter_if #(
    parameter int NPads = 32,
    parameter int CntW  = 8
);
    logic [NPads-1:0] in_i;
    logic [NPads-1:0] filter_en_i;
    logic [CntW-1:0]  thresh_i;
    logic [NPads-1:0] evt_en_i;
    logic [NPads-1:0] evt_clr_i;
    logic [NPads-1:0] in_o;
    logic [NPads-1:0] rise_o;
    logic [NPads-1:0] fall_o;
    logic [NPads-1:0] evt_o;

    modport master (
        output in_i, filter_en_i, thresh_i, evt_en_i, evt_clr_i,
        input  in_o, rise_o, fall_o, evt_o
    );

    modport slave (
        input  in_i, filter_en_i, thresh_i, evt_en_i, evt_clr_i,
        output in_o, rise_o, fall_o, evt_o
    );
endinterface

// File: rtl/pad_in_filter.sv
// Per-pad input conditioning: synchroniser, optional stable-count debounce,
// registered rise/fall pulses and sticky per-pad event flags.
module pad_in_filter #(
    parameter int NPads      = 32,
    parameter int CntW       = 8,
    parameter int SyncStages = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    pad_in_filter_if.slave   pads
);

    localparam logic [CntW-1:0] CntMax = '1;

    logic [NPads-1:0] sync_q [SyncStages];
    logic [NPads-1:0] s;

    logic [CntW-1:0]  cnt_q    [NPads];
    logic [CntW-1:0]  cnt_next [NPads];
    logic [NPads-1:0] in_q;
    logic [NPads-1:0] in_next;
    logic [NPads-1:0] rise_next;
    logic [NPads-1:0] fall_next;
    logic [NPads-1:0] rise_q;
    logic [NPads-1:0] fall_q;
    logic [NPads-1:0] evt_q;

    assign s = sync_q[SyncStages-1];

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes the
    // synchroniser chain shift one stage per clock instead of collapsing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SyncStages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pads.in_i;
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the if/else chain leaves a value unassigned and infers a latch.
    always_comb begin
        in_next = in_q;
        for (int k = 0; k < NPads; k++) begin
            cnt_next[k] = cnt_q[k];
            if (!pads.filter_en_i[k]) begin
                in_next[k]  = s[k];
                cnt_next[k] = '0;
            end else if (s[k] == in_q[k]) begin
                cnt_next[k] = '0;
            end else if (cnt_q[k] >= pads.thresh_i) begin
                // >= rather than == so a threshold lowered mid-count applies at once
                in_next[k]  = s[k];
                cnt_next[k] = '0;
            end else if (cnt_q[k] != CntMax) begin
                cnt_next[k] = cnt_q[k] + CntW'(1);
            end
        end
        rise_next = in_next & ~in_q;
        fall_next = ~in_next & in_q;
    end

    // NOTE: the counter array is reset explicitly; a pending count must not
    // survive reset, so it cannot be left as an unreset memory.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= '0;
            for (int k = 0; k < NPads; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            in_q   <= in_next;
            rise_q <= rise_next;
            fall_q <= fall_next;
            // A fresh edge outranks a coincident clear
            evt_q  <= (evt_q & ~pads.evt_clr_i) |
                      (pads.evt_en_i & (rise_next | fall_next));
            for (int k = 0; k < NPads; k++) begin
                cnt_q[k] <= cnt_next[k];
            end
        end
    end

    assign pads.in_o   = in_q;
    assign pads.rise_o = rise_q;
    assign pads.fall_o = fall_q;
    assign pads.evt_o  = evt_q;

endmodule

// File: tb/tb_pad_in_filter.sv
// Directed bench for pad_in_filter: latency, debounce, glitch restart,
// threshold change, sticky events and reset.
module tb_pad_in_filter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pad_in_filter_if #(.NPads(32), .CntW(8)) pads ();

    pad_in_filter #(.NPads(32), .CntW(8), .SyncStages(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .pads   (pads)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; outputs are then sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [8:0] glitch_pat;

        rst_n             = 1'b0;
        pads.in_i        = '0;
        pads.filter_en_i = '0;
        pads.thresh_i    = '0;
        pads.evt_en_i    = '0;
        pads.evt_clr_i   = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check("reset_in_o",   pads.in_o,   32'h0);
        check("reset_rise_o", pads.rise_o, 32'h0);
        check("reset_fall_o", pads.fall_o, 32'h0);
        check("reset_evt_o",  pads.evt_o,  32'h0);

        // Filter off, pad 0: change before edge N, in_o at edge N+2
        pads.in_i[0] = 1'b1;
        step(2);
        check("off_pad0_early", pads.in_o[0], 1'b0);
        step(1);
        check("off_pad0_in",    pads.in_o[0],   1'b1);
        check("off_pad0_rise",  pads.rise_o[0], 1'b1);
        step(1);
        check("off_pad0_rise_end", pads.rise_o[0], 1'b0);
        check("off_pad0_hold",     pads.in_o[0],   1'b1);

        // Filter on, pad 3, T=4: 7 edges of latency
        pads.filter_en_i[3] = 1'b1;
        pads.thresh_i       = 8'd4;
        step(1);
        pads.in_i[3] = 1'b1;
        step(6);
        check("t4_pad3_early", pads.in_o[3], 1'b0);
        step(1);
        check("t4_pad3_in",   pads.in_o[3],   1'b1);
        check("t4_pad3_rise", pads.rise_o[3], 1'b1);
        step(1);
        check("t4_pad3_rise_end", pads.rise_o[3], 1'b0);

        // 4-cycle low pulse on pad 3 is too short for T=4
        pads.in_i[3] = 1'b0;
        step(4);
        pads.in_i[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_pad3_short_pulse_in",   pads.in_o[3],   1'b1);
            check("t4_pad3_short_pulse_fall", pads.fall_o[3], 1'b0);
            step(1);
        end

        // Glitch restart, pad 5, T=3: high 3, low 1, high 5 (sampled values)
        pads.filter_en_i[5] = 1'b1;
        pads.thresh_i       = 8'd3;
        step(1);
        glitch_pat = 9'b1_1111_0111;
        for (int i = 0; i < 9; i++) begin
            pads.in_i[5] = glitch_pat[i];
            step(1);
            check("glitch_pad5_hold", pads.in_o[5], 1'b0);
        end
        step(1);
        check("glitch_pad5_in",   pads.in_o[5],   1'b1);
        check("glitch_pad5_rise", pads.rise_o[5], 1'b1);
        step(1);
        check("glitch_pad5_rise_end", pads.rise_o[5], 1'b0);

        // Threshold lowered mid-count, pad 9: T=200, count to 50, then T=10
        pads.filter_en_i[9] = 1'b1;
        pads.thresh_i       = 8'd200;
        step(1);
        pads.in_i[9] = 1'b1;
        step(52);
        check("thresh_pad9_pending", pads.in_o[9], 1'b0);
        pads.thresh_i = 8'd10;
        step(1);
        check("thresh_pad9_in",   pads.in_o[9],   1'b1);
        check("thresh_pad9_rise", pads.rise_o[9], 1'b1);

        // Events on pad 7 (unfiltered); no other pad is event-enabled
        pads.in_i[7] = 1'b1;
        step(4);
        check("evt_disabled_no_set", pads.evt_o, 32'h0);
        pads.evt_en_i[7] = 1'b1;
        pads.in_i[7]     = 1'b0;
        step(2);
        check("evt_pad7_before_fall", pads.evt_o, 32'h0);
        step(1);
        check("evt_pad7_fall",     pads.fall_o[7], 1'b1);
        check("evt_pad7_set",      pads.evt_o,     32'h80);
        step(3);
        check("evt_pad7_sticky",   pads.evt_o,     32'h80);
        // Clear lands on the same edge as a new rise: flag stays set
        pads.in_i[7] = 1'b1;
        step(2);
        pads.evt_clr_i[7] = 1'b1;
        step(1);
        pads.evt_clr_i[7] = 1'b0;
        check("evt_pad7_rise",         pads.rise_o[7], 1'b1);
        check("evt_pad7_clr_vs_edge",  pads.evt_o,     32'h80);
        step(1);
        check("evt_pad7_still_set",    pads.evt_o,     32'h80);
        pads.evt_clr_i[7] = 1'b1;
        step(1);
        pads.evt_clr_i[7] = 1'b0;
        check("evt_pad7_cleared",      pads.evt_o,     32'h0);

        // Reset mid-count on pad 3 (T=4) with in_o=1
        pads.thresh_i = 8'd4;
        pads.in_i[3]  = 1'b0;
        step(4);
        check("rst_pad3_pending", pads.in_o[3], 1'b1);
        rst_n = 1'b0;
        step(1);
        check("rst_mid_in_o",   pads.in_o,   32'h0);
        check("rst_mid_rise_o", pads.rise_o, 32'h0);
        check("rst_mid_fall_o", pads.fall_o, 32'h0);
        check("rst_mid_evt_o",  pads.evt_o,  32'h0);
        rst_n        = 1'b1;
        pads.in_i[3] = 1'b1;
        step(2);
        check("rst_repro_early", pads.in_o, 32'h0);
        step(1);
        check("rst_repro_unfilt_in",   pads.in_o,   32'h0000_0081);
        check("rst_repro_unfilt_rise", pads.rise_o, 32'h0000_0081);
        check("rst_repro_evt",         pads.evt_o,  32'h0000_0080);
        step(3);
        check("rst_repro_filt_wait", pads.in_o, 32'h0000_0081);
        step(1);
        check("rst_repro_filt_in",   pads.in_o,   32'h0000_02A9);
        check("rst_repro_filt_rise", pads.rise_o, 32'h0000_0228);
        check("rst_repro_no_fall",   pads.fall_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
